// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: register address of the LCR,
// word-length encodings, the transmit sequencer state type, the latched frame
// configuration and the stop-bit duration helper.
// -----------------------------------------------------------------------------
package uart_pkg;

  // Line control register address in the UART register map.
  localparam logic [7:0] LCR_ADDR = 8'h0C;

  // WLS encodings (word length).
  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  // Stop-bit durations in 16x baud ticks.
  localparam int STOP_TICKS_1   = 16;
  localparam int STOP_TICKS_1P5 = 24;
  localparam int STOP_TICKS_2   = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // LCR fields captured at TSR load; held for the whole frame.
  typedef struct packed {
    logic [1:0] wls;
    logic       stb;
    logic       pen;
    logic       eps;
    logic       sp;
  } frame_cfg_t;

  // Stop duration in ticks, scaled from the 16x reference to the actual
  // oversample rate. STB selects 1.5 stop bits only for 5-bit words.
  function automatic logic [5:0] stop_ticks(input frame_cfg_t cfg, input int oversample);
    int base;
    if (!cfg.stb)              base = STOP_TICKS_1;
    else if (cfg.wls == WLS_5) base = STOP_TICKS_1P5;
    else                       base = STOP_TICKS_2;
    return 6'(base * oversample / 16);
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// -----------------------------------------------------------------------------
// uart_tx_frame_if
// Bus-side interface of the transmitter holding register.
//   thr_data  : byte to transmit (master -> slave)
//   thr_wr    : write strobe (master -> slave)
//   thr_ready : THR can accept a write this cycle (slave -> master)
//   thre      : THR empty status (slave -> master)
//   temt      : THR and TSR empty, line idle (slave -> master)
//   dbg_state : current transmit sequencer state (slave -> master)
//
// Handshake: thr_wr acts as valid and thr_ready as ready. A byte is taken on
// the rising clock edge where both are high; thr_data must be stable while
// thr_wr is high. A write while thr_ready is low is not held or retried -- it
// is dropped and the slave state does not change.
// -----------------------------------------------------------------------------
interface uart_tx_frame_if;
  import uart_pkg::*;

  logic [7:0] thr_data;
  logic       thr_wr;
  logic       thr_ready;
  logic       thre;
  logic       temt;
  tx_state_t  dbg_state;

  modport master (
    output thr_data, thr_wr,
    input  thr_ready, thre, temt, dbg_state
  );

  modport slave (
    input  thr_data, thr_wr,
    output thr_ready, thre, temt, dbg_state
  );

endinterface

// File: rtl/uart_tx_parity.sv
// -----------------------------------------------------------------------------
// uart_tx_parity
// Combinational parity bit for one transmit word.
//   i_data   : word held in the TSR (bits above the word length ignored)
//   i_wls    : word length select
//   i_eps    : even parity select
//   i_sp     : stick parity
//   o_parity : parity bit to place on the line
// -----------------------------------------------------------------------------
module uart_tx_parity
  import uart_pkg::*;
(
  input  logic [7:0] i_data,
  input  logic [1:0] i_wls,
  input  logic       i_eps,
  input  logic       i_sp,
  output logic       o_parity
);

  logic [7:0] w_mask;
  logic       w_xor;

  always_comb begin
    w_mask = 8'hFF;
    case (i_wls)
      WLS_5:   w_mask = 8'h1F;
      WLS_6:   w_mask = 8'h3F;
      WLS_7:   w_mask = 8'h7F;
      default: w_mask = 8'hFF;
    endcase
    w_xor = ^(i_data & w_mask);
    // Stick parity forces a constant level, the inverse of EPS.
    if (i_sp)       o_parity = ~i_eps;
    else if (i_eps) o_parity = w_xor;
    else            o_parity = ~w_xor;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
// UART transmitter: one-entry holding register (THR) feeding a transmit shift
// register (TSR), serialised onto txd with framing from the LCR fields.
//   m_clk     : system clock
//   reset     : asynchronous active-low reset
//   baud_tick : one-cycle pulse at OVERSAMPLE x baud rate
//   WLS/STB/PEN/EPS/SP : LCR framing fields, latched at each TSR load
//   BC        : break control, applied live to the registered txd
//   bus       : THR write handshake and status (uart_tx_frame_if.slave)
//   txd       : registered serial output
// OVERSAMPLE must be a power of two in 8..16.
// -----------------------------------------------------------------------------
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic                  m_clk,
  input  logic                  reset,
  input  logic                  baud_tick,
  input  logic [1:0]            WLS,
  input  logic                  STB,
  input  logic                  PEN,
  input  logic                  EPS,
  input  logic                  SP,
  input  logic                  BC,
  uart_tx_frame_if.slave        bus,
  output logic                  txd
);

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

  tx_state_t  r_state;
  logic [7:0] r_thr;
  logic       r_thr_full;
  logic [7:0] r_tsr;
  frame_cfg_t r_cfg;
  logic [3:0] r_tick_cnt;
  logic [2:0] r_bit_idx;
  logic [4:0] r_stop_cnt;
  logic       r_txd;

  frame_cfg_t w_lcr;
  logic       w_bit_end;
  logic       w_last_data;
  logic [4:0] w_stop_last;
  logic       w_stop_end;
  logic       w_load;
  logic       w_thr_ready;
  logic       w_wr;
  logic       w_parity;
  logic       w_frame_bit;

  assign w_lcr       = '{wls: WLS, stb: STB, pen: PEN, eps: EPS, sp: SP};
  assign w_bit_end   = baud_tick && (r_tick_cnt == TICK_LAST);
  assign w_last_data = (r_bit_idx == ({1'b0, r_cfg.wls} + 3'd4));
  assign w_stop_last = 5'(stop_ticks(r_cfg, OVERSAMPLE) - 6'd1);
  assign w_stop_end  = (r_state == STOP) && baud_tick && (r_stop_cnt == w_stop_last);

  // TSR loads from a full THR either when idle (no tick needed) or on the
  // final stop tick, which chains frames with no idle gap.
  assign w_load      = r_thr_full && ((r_state == IDLE) || w_stop_end);
  // Ready reflects the THR as it will be after a same-cycle load.
  assign w_thr_ready = ~r_thr_full | w_load;
  assign w_wr        = bus.thr_wr && w_thr_ready;

  uart_tx_parity u_parity (
    .i_data   (r_tsr),
    .i_wls    (r_cfg.wls),
    .i_eps    (r_cfg.eps),
    .i_sp     (r_cfg.sp),
    .o_parity (w_parity)
  );

  always_comb begin
    w_frame_bit = 1'b1;
    case (r_state)
      START:   w_frame_bit = 1'b0;
      DATA:    w_frame_bit = r_tsr[r_bit_idx];
      PARITY:  w_frame_bit = w_parity;
      default: w_frame_bit = 1'b1;
    endcase
  end

  always_ff @(posedge m_clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_thr      <= 8'h00;
      r_thr_full <= 1'b0;
      r_tsr      <= 8'h00;
      r_cfg      <= '0;
      r_tick_cnt <= 4'd0;
      r_bit_idx  <= 3'd0;
      r_stop_cnt <= 5'd0;
      r_txd      <= 1'b1;
    end else begin
      // Break masks the line only; the sequencer keeps consuming frames.
      r_txd <= w_frame_bit & ~BC;

      // A write in the same cycle as a load refills the THR.
      if (w_wr) begin
        r_thr      <= bus.thr_data;
        r_thr_full <= 1'b1;
      end else if (w_load) begin
        r_thr_full <= 1'b0;
      end

      if (w_load) begin
        r_tsr <= r_thr;
        r_cfg <= w_lcr;
      end

      case (r_state)
        IDLE: begin
          // A tick coinciding with the load is not counted.
          if (w_load) begin
            r_state    <= START;
            r_tick_cnt <= 4'd0;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_tick_cnt <= 4'd0;
            r_bit_idx  <= 3'd0;
            r_state    <= DATA;
          end else if (baud_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_tick_cnt <= 4'd0;
            if (w_last_data) begin
              r_stop_cnt <= 5'd0;
              r_state    <= r_cfg.pen ? PARITY : STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else if (baud_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_tick_cnt <= 4'd0;
            r_stop_cnt <= 5'd0;
            r_state    <= STOP;
          end else if (baud_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
          end
        end
        STOP: begin
          if (w_stop_end) begin
            r_tick_cnt <= 4'd0;
            r_stop_cnt <= 5'd0;
            r_state    <= r_thr_full ? START : IDLE;
          end else if (baud_tick) begin
            r_stop_cnt <= r_stop_cnt + 5'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign txd           = r_txd;
  assign bus.thr_ready = w_thr_ready;
  assign bus.thre      = ~r_thr_full;
  assign bus.temt      = ~r_thr_full && (r_state == IDLE);
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame
// Bench for uart_tx_frame. Expected line bits and frame durations are pushed
// when a byte is written; a line monitor samples txd mid-bit and pops them.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int OS  = 16;
  localparam int DIV = 4;   // clocks per baud tick

  // ---------------- clock / reset ----------------
  logic m_clk;
  logic reset;
  logic baud_tick;
  logic [1:0] wls;
  logic stb, pen, eps, sp, bc;
  logic txd;

  uart_tx_frame_if bus_if ();

  uart_tx_frame #(.OVERSAMPLE(OS)) dut (
    .m_clk     (m_clk),
    .reset     (reset),
    .baud_tick (baud_tick),
    .WLS       (wls),
    .STB       (stb),
    .PEN       (pen),
    .EPS       (eps),
    .SP        (sp),
    .BC        (bc),
    .bus       (bus_if),
    .txd       (txd)
  );

  initial m_clk = 1'b0;
  always #5 m_clk = ~m_clk;

  // Tick generator: driven on the falling edge, consumed on the next rise.
  int tick_div = 0;
  initial baud_tick = 1'b0;
  always @(negedge m_clk) begin
    tick_div  = (tick_div + 1) % DIV;
    baud_tick = (tick_div == 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];
  int         len_q[$];
  int         ticks_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  bit         mon_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference frame model from the current LCR settings.
  task automatic push_frame(input logic [7:0] d);
    int   n;
    int   stop_t;
    logic x;
    logic p;
    n = 5 + int'(wls);
    x = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(d[i]);
      x = x ^ d[i];
    end
    if (pen) begin
      if (sp)       p = ~eps;
      else if (eps) p = x;
      else          p = ~x;
      exp_q.push_back(p);
    end
    exp_q.push_back(1'b1);
    if (!stb)            stop_t = 16;
    else if (wls == 2'b00) stop_t = 24;
    else                 stop_t = 32;
    len_q.push_back(n + 2 + (pen ? 1 : 0));
    ticks_q.push_back(16 * (n + 1 + (pen ? 1 : 0)) + stop_t);
  endtask

  // ---------------- line monitor ----------------
  int m_st = 0;
  int m_tcnt, m_nb, m_idx, m_ticks;

  task automatic mon_start();
    check_eq("frame_expected", (len_q.size() != 0), 1);
    if (len_q.size() == 0) begin
      m_st = 3;
    end else begin
      m_nb    = len_q.pop_front();
      m_ticks = ticks_q.pop_front();
      m_idx   = 0;
      m_tcnt  = baud_tick ? 1 : 0;
      m_st    = 1;
    end
  endtask

  initial begin : monitor
    forever begin
      @(posedge m_clk);
      #1;
      if (!mon_en || !reset) begin
        m_st = 0;
      end else begin
        case (m_st)
          0: if (txd == 1'b0) mon_start();
          1: begin
            if (baud_tick) begin
              m_tcnt++;
              if (m_tcnt == OS / 2 + OS * m_idx) begin
                check_eq($sformatf("bit%0d", m_idx), txd, exp_q.pop_front());
                m_idx++;
                if (m_idx == m_nb) m_st = 2;
              end
            end
          end
          2: begin
            if (txd == 1'b0) begin
              check_eq("frame_ticks_b2b", m_tcnt, m_ticks);
              mon_start();
            end else begin
              if (baud_tick) m_tcnt++;
              if (bus_if.temt) begin
                check_eq("frame_ticks", m_tcnt, m_ticks);
                m_st = 0;
              end
            end
          end
          default: if (bus_if.temt) m_st = 0;
        endcase
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_lcr(input logic [1:0] w, input logic s, input logic pe,
                         input logic ep, input logic stk);
    @(negedge m_clk);
    wls = w; stb = s; pen = pe; eps = ep; sp = stk;
  endtask

  task automatic write_byte(input logic [7:0] d, input bit expect_frame);
    int k = 0;
    @(negedge m_clk);
    while (!bus_if.thr_ready && k < 5000) begin
      @(negedge m_clk);
      k++;
    end
    check_eq("wr_ready", bus_if.thr_ready, 1);
    bus_if.thr_data = d;
    bus_if.thr_wr   = 1'b1;
    if (expect_frame) push_frame(d);
    @(negedge m_clk);
    bus_if.thr_wr = 1'b0;
  endtask

  task automatic write_dropped(input logic [7:0] d);
    @(negedge m_clk);
    check_eq("drop_ready", bus_if.thr_ready, 0);
    check_eq("drop_thre", bus_if.thre, 0);
    bus_if.thr_data = d;
    bus_if.thr_wr   = 1'b1;
    @(negedge m_clk);
    bus_if.thr_wr = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge m_clk);
    while (!bus_if.temt && k < 20000) begin
      @(negedge m_clk);
      k++;
    end
    check_eq("idle", bus_if.temt, 1);
    repeat (4) @(negedge m_clk);
  endtask

  // Waits for the start-bit edge; returns the ticks consumed at that edge.
  task automatic wait_fall(output int t);
    int k = 0;
    t = 0;
    @(posedge m_clk); #1;
    while (txd !== 1'b0 && k < 400) begin
      @(posedge m_clk); #1;
      k++;
    end
    check_eq("fall_seen", txd, 0);
    t = baud_tick ? 1 : 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int t;
    int k;
    int brk_bad;
    reset = 1'b0;
    wls = 2'b11; stb = 1'b0; pen = 1'b0; eps = 1'b0; sp = 1'b0; bc = 1'b0;
    bus_if.thr_data = 8'h00;
    bus_if.thr_wr   = 1'b0;
    repeat (3) @(negedge m_clk);
    check_eq("rst_txd", txd, 1);
    check_eq("rst_thre", bus_if.thre, 1);
    check_eq("rst_temt", bus_if.temt, 1);
    check_eq("rst_ready", bus_if.thr_ready, 1);
    check_eq("rst_state", bus_if.dbg_state, IDLE);
    reset = 1'b1;
    repeat (3) @(negedge m_clk);
    mon_en = 1'b1;

    // 8N1, 0x55
    set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    write_byte(8'h55, 1'b1);
    wait_idle();

    // 5 bits, 1.5 stop, even parity
    set_lcr(2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    write_byte(8'h1F, 1'b1);
    wait_idle();
    write_byte(8'hE0, 1'b1);
    wait_idle();

    // stick parity, 7 bits
    set_lcr(2'b10, 1'b0, 1'b1, 1'b0, 1'b1);
    write_byte(8'h00, 1'b1);
    wait_idle();
    set_lcr(2'b10, 1'b0, 1'b1, 1'b1, 1'b1);
    write_byte(8'h00, 1'b1);
    wait_idle();

    // odd parity, 6 bits, 2 stop
    set_lcr(2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    write_byte(8'h2B, 1'b1);
    wait_idle();

    // back-to-back with a dropped third write
    set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    write_byte(8'hA5, 1'b1);
    write_byte(8'h3C, 1'b1);
    write_dropped(8'h99);
    wait_idle();

    // randomised framing
    for (int i = 0; i < 4; i++) begin
      set_lcr(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      write_byte(8'($urandom_range(0, 255)), 1'b1);
      wait_idle();
    end

    // break mid-frame, 8N1 0xFF
    mon_en = 1'b0;
    set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    write_byte(8'hFF, 1'b0);
    wait_fall(t);
    brk_bad = 0;
    k = 0;
    while (k < 2000) begin
      @(posedge m_clk); #1;
      k++;
      if (bc && txd !== 1'b0) brk_bad++;
      if (baud_tick) begin
        t++;
        if (t == 88)  check_eq("brk_pre", txd, 1);
        if (t == 100) bc = 1'b1;
        if (t == 140) bc = 1'b0;
        if (t == 142) check_eq("brk_release", txd, 1);
        if (t == 150) check_eq("brk_stop", txd, 1);
      end
      if (bus_if.temt) break;
    end
    check_eq("brk_low", brk_bad, 0);
    check_eq("brk_len", t, 160);
    wait_idle();

    // reset mid-DATA
    write_byte(8'h0F, 1'b0);
    wait_fall(t);
    while (t < 40) begin
      @(posedge m_clk); #1;
      if (baud_tick) t++;
    end
    @(negedge m_clk);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_txd", txd, 1);
    check_eq("mid_rst_thre", bus_if.thre, 1);
    check_eq("mid_rst_temt", bus_if.temt, 1);
    check_eq("mid_rst_ready", bus_if.thr_ready, 1);
    repeat (2) @(negedge m_clk);
    reset = 1'b1;
    repeat (2) @(negedge m_clk);
    check_eq("post_rst_txd", txd, 1);
    mon_en = 1'b1;
    write_byte(8'h96, 1'b1);
    wait_idle();

    repeat (20) @(negedge m_clk);
    check_eq("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Transmit-side consumer of the line-control fields (WLS, STB, PEN, EPS, SP, BC) that the LCR register at 0Ch produces.
- Accepts bytes from the bus side through a one-entry holding register (THR) and serialises them from a transmit shift register (TSR) onto txd.
- Framing, parity and stop-bit count follow the LCR fields.
- Sits between the register file and the UART pin; bit timing comes from an external 16x baud-tick pulse.

Parameters:
- OVERSAMPLE, 16, baud ticks per bit period. Must be a power of two, 8..16.

Ports:
- m_clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- baud_tick  in  1  one-cycle pulse at OVERSAMPLE x baud rate
- WLS  in  2  word length: 00=5, 01=6, 10=7, 11=8 bits
- STB  in  1  0=1 stop bit; 1=1.5 stop (5-bit words) or 2 stop (other lengths)
- PEN  in  1  parity enable
- EPS  in  1  even parity select
- SP  in  1  stick parity
- BC  in  1  break control
- thr_data  in  8  byte to transmit
- thr_wr  in  1  write strobe for THR
- thr_ready  out  1  THR empty and can accept a write
- thre  out  1  THR empty status
- temt  out  1  THR and TSR both empty, line idle
- txd  out  1  serial output, registered

Behaviour:
- Reset (asynchronous, reset=0):
  - txd=1, thre=1, temt=1, thr_ready=1.
  - State=IDLE; all counters 0.
  - Effective immediately, including mid-frame. The partial frame is discarded and is not resumed after reset.
- THR write:
  - thr_wr && thr_ready loads THR and drops thre/thr_ready on the next edge.
  - thr_wr while THR is full is ignored; the data is lost and no state changes.
- TSR load:
  - Occurs in IDLE when THR is full, on any cycle (no tick needed).
  - TSR <= THR; THR becomes empty (thre=1 next edge); the LCR fields are latched into a frame-config register.
  - The frame uses the latched config for its full duration. LCR changes take effect at the next frame.
- A THR write on the same cycle the TSR loads from THR is accepted, because thr_ready reflects the empty-after-load state combinationally.
- States: IDLE -> START -> DATA -> (PARITY if PEN) -> STOP -> IDLE.
  - STOP goes directly to START if THR is full, giving back-to-back frames with no idle gap.
- Tick counter: 4 bits. It advances only on baud_tick, and one bit period = OVERSAMPLE ticks.
- Line levels and durations:
  - START: txd=0 for one bit period.
  - DATA: LSB first; bit index 0..(WLS+4). Bits above the word length are never sent.
  - PARITY bit:
    - SP=0, EPS=1: XOR of the sent data bits (even parity).
    - SP=0, EPS=0: the inverse of that XOR (odd parity).
    - SP=1: parity bit = ~EPS.
  - STOP: txd=1 for 16, 24 or 32 ticks, per STB/WLS. The stop counter is 5 bits and counts ticks.
- temt=0 from TSR load until the last stop tick completes and THR is empty.
- Break: txd is registered as (frame_bit & ~BC), using the live BC input rather than the latched copy.
  - BC=1 forces txd=0 on the next edge.
  - The frame sequencer keeps running, so frames are consumed silently.
  - On BC deassertion, txd returns to the current frame level on the next edge.
- baud_tick arriving on the same cycle as a TSR load is ignored for that frame. The start bit begins counting at the next tick.

Decomposition:
- Shared package uart_pkg holds:
  - LCR address constant 8'h0C
  - WLS encodings
  - tx state enum {IDLE, START, DATA, PARITY, STOP}
  - stop-tick constants 16/24/32
- One natural sub-module, uart_tx_parity: combinational parity bit from data[7:0], WLS, EPS, SP (masks bits above the word length).
- THR and TSR stay in the top module.

Test Plan:
- 8N1 (WLS=11, STB=0, PEN=0), write 0x55 -> txd sequence 0,1,0,1,0,1,0,1,0,1. Each bit lasts 16 ticks; temt returns to 1 after 160 ticks.
- 5-bit, 1.5 stop, even parity (WLS=00, STB=1, PEN=1, EPS=1), write 0x1F -> data 1,1,1,1,1, parity 1, stop high for 24 ticks. Bits 7:5 never appear.
- Stick parity (PEN=1, SP=1, EPS=0), 7-bit word, write 0x00 -> parity bit 1. With EPS=1 -> parity bit 0.
- Back-to-back: write 0xA5, then 0x3C once thre=1 -> second start bit immediately follows the last stop tick. A third write while THR is full is dropped.
- Break: assert BC for 40 ticks mid-frame -> txd=0 throughout. The frame still completes on schedule, and txd=1 (stop) after deassertion.
- Reset mid-DATA (reset=0 for 2 cycles) -> txd=1, thre=temt=1 within the same cycle the reset asserts. A new write afterwards produces a clean frame.
